// File: rtl/cipher_pkg.sv
// Shared types and constants for the streaming cipher engine.
package cipher_pkg;

  typedef enum logic [1:0] {
    KEY_EMPTY = 2'd0,
    KEY_LOAD  = 2'd1,
    ARMED     = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/cipher_key_store.sv
// SEC_LEN x DATA_W key register file: serial write port with fill
// counter and full flag, one combinational read port.
module cipher_key_store
  import cipher_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SEC_LEN = 3,
  parameter int IDX_W   = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_restart,
  input  logic [DATA_W-1:0] i_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_fill_done
);

  localparam int CW = $clog2(SEC_LEN + 1);

  logic [DATA_W-1:0] r_key [SEC_LEN];
  logic [CW-1:0]     r_wr_cnt;
  logic              r_full;
  logic [CW-1:0]     w_wr_idx;
  logic [CW-1:0]     w_cnt_nxt;

  // A restart (first symbol of a fresh or replacement key) writes slot 0.
  always_comb begin
    w_wr_idx    = i_restart ? '0 : r_wr_cnt;
    w_cnt_nxt   = w_wr_idx + CW'(1);
    o_fill_done = i_we && (w_cnt_nxt == CW'(SEC_LEN));
  end

  // Key storage, fill counter and full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SEC_LEN; i++) r_key[i] <= '0;
      r_wr_cnt <= '0;
      r_full   <= 1'b0;
    end else if (i_we) begin
      r_key[w_wr_idx] <= i_data;
      r_wr_cnt        <= w_cnt_nxt;
      r_full          <= (w_cnt_nxt == CW'(SEC_LEN));
    end
  end

  assign o_rd_data = r_key[i_rd_idx];
  assign o_full    = r_full;

endmodule

// File: rtl/stream_cipher_engine.sv
// Streaming byte cipher: serial key load, valid/ready in and out,
// one cycle latency. Optional chained mode via `CIPHER_CHAIN_EN.
module stream_cipher_engine
  import cipher_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SEC_LEN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_we,
  input  logic [DATA_W-1:0] key_data,
  output logic              key_ok,
  input  logic              mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_k_idx;
  logic [IDX_W-1:0]  w_k_adv;
  logic              r_mode;
  logic              w_mode;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_last;
  logic              r_err;
  logic              w_s_ready;
  logic              w_acc;
  logic              w_key_wr;
  logic              w_key_restart;
  logic              w_key_full;
  logic              w_fill_done;
  logic [DATA_W-1:0] w_key_sym;
  logic [DATA_W-1:0] w_y;
  logic [DATA_W-1:0] w_c_nxt;
`ifdef CIPHER_CHAIN_EN
  logic [DATA_W-1:0] r_c_prev;
`endif

  // Key writes are locked out while a message is running.
  assign w_key_wr      = key_we && (r_state != RUN);
  assign w_key_restart = (r_state != KEY_LOAD);

  cipher_key_store #(
    .DATA_W  (DATA_W),
    .SEC_LEN (SEC_LEN),
    .IDX_W   (IDX_W)
  ) u_key (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (w_key_wr),
    .i_restart   (w_key_restart),
    .i_data      (key_data),
    .i_rd_idx    (r_k_idx),
    .o_rd_data   (w_key_sym),
    .o_full      (w_key_full),
    .o_fill_done (w_fill_done)
  );

  assign w_s_ready = w_key_full && (!r_m_valid || m_ready);
  assign w_acc     = s_valid && w_s_ready;

  // Per-symbol transform; mode comes from the port on the first byte.
  always_comb begin
    w_mode  = (r_state == RUN) ? r_mode : mode;
    w_k_adv = (r_k_idx == IDX_W'(SEC_LEN - 1)) ? '0 : r_k_idx + IDX_W'(1);
`ifdef CIPHER_CHAIN_EN
    if (w_mode == MODE_ENC) begin
      w_y     = s_data + w_key_sym + r_c_prev;
      w_c_nxt = w_y;
    end else begin
      w_y     = s_data - w_key_sym - r_c_prev;
      w_c_nxt = s_data;
    end
`else
    w_c_nxt = '0;
    if (w_mode == MODE_ENC) w_y = s_data + w_key_sym;
    else                    w_y = s_data - w_key_sym;
`endif
  end

  // Next-state logic; a rekey in ARMED takes priority over starting a message.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      KEY_EMPTY: if (key_we) w_next = (SEC_LEN == 1) ? ARMED : KEY_LOAD;
      KEY_LOAD:  if (w_fill_done) w_next = ARMED;
      ARMED: begin
        if (key_we)                w_next = (SEC_LEN == 1) ? ARMED : KEY_LOAD;
        else if (w_acc && !s_last) w_next = RUN;
      end
      RUN:       if (w_acc && s_last) w_next = ARMED;
      default:   w_next = KEY_EMPTY;
    endcase
  end

  // State register and sticky key-write-during-message error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= KEY_EMPTY;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (key_we && (r_state == RUN)) r_err <= 1'b1;
    end
  end

  // Message context: key index, latched mode and chain value; cleared
  // whenever the accepted byte leaves the FSM outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k_idx <= '0;
      r_mode  <= MODE_ENC;
`ifdef CIPHER_CHAIN_EN
      r_c_prev <= '0;
`endif
    end else if (w_acc) begin
      if (r_state == ARMED) r_mode <= mode;
      r_k_idx <= (w_next == RUN) ? w_k_adv : '0;
`ifdef CIPHER_CHAIN_EN
      r_c_prev <= (w_next == RUN) ? w_c_nxt : '0;
`endif
    end
  end

  // Output register: load on accept, otherwise drain on m_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_acc) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_y;
      r_m_last  <= s_last;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign key_ok  = w_key_full;
  assign s_ready = w_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign busy    = (r_state == RUN);
  assign err     = r_err;

endmodule

// File: tb/tb_stream_cipher_engine.sv
// Directed scoreboard bench for stream_cipher_engine (default build,
// CIPHER_CHAIN_EN undefined), key length 3, 8-bit symbols.
module tb_stream_cipher_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_we = 1'b0;
  logic [7:0] key_data = '0;
  logic       key_ok;
  logic       mode = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] sb[$];

  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  stream_cipher_engine #(.DATA_W(8), .SEC_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_data(key_data),
    .key_ok(key_ok), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: a transfer completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_output", {31'd0, m_valid}, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("m_data", {24'd0, m_data}, {24'd0, e[7:0]});
        chk("m_last", {31'd0, m_last}, {31'd0, e[8]});
      end
    end
  end

  task automatic load_key(input logic [7:0] d);
    key_we = 1'b1; key_data = d;
    @(posedge clk); #1;
    key_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic md, input logic [7:0] exp_d);
    int t;
    t = 0;
    s_valid = 1'b1; s_data = d; s_last = last; mode = md;
    @(negedge clk);
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept", {31'd0, s_ready}, 32'd1);
    if (s_ready) sb.push_back({last, exp_d});
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key_ok"},  {31'd0, key_ok},  32'd0);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_m_data"},  {24'd0, m_data},  32'd0);
    chk({tag, "_m_last"},  {31'd0, m_last},  32'd0);
    chk({tag, "_busy"},    {31'd0, busy},    32'd0);
    chk({tag, "_err"},     {31'd0, err},     32'd0);
  endtask

  initial begin
    // Reset values
    #12;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Key load: input blocked until the third symbol
    load_key(8'h41);
    chk("s_ready_k1", {31'd0, s_ready}, 32'd0);
    load_key(8'h42);
    chk("key_ok_k2", {31'd0, key_ok}, 32'd0);
    chk("s_ready_k2", {31'd0, s_ready}, 32'd0);
    load_key(8'h43);
    chk("key_ok_k3", {31'd0, key_ok}, 32'd1);
    chk("s_ready_k3", {31'd0, s_ready}, 32'd1);

    // Single byte encrypt / decrypt
    send(8'h48, 1'b1, ENC, 8'h89);
    drain();
    send(8'h89, 1'b1, DEC, 8'h48);
    drain();

    // Key wrap across four bytes
    send(8'h48, 1'b0, ENC, 8'h89);
    chk("busy_run", {31'd0, busy}, 32'd1);
    send(8'h45, 1'b0, ENC, 8'h87);
    send(8'h4C, 1'b0, ENC, 8'h8F);
    send(8'h4C, 1'b1, ENC, 8'h8D);
    drain();
    chk("busy_idle", {31'd0, busy}, 32'd0);

    // Modulo wrap and output backpressure
    m_ready = 1'b0;
    send(8'hF0, 1'b0, ENC, 8'h31);
    s_valid = 1'b1; s_data = 8'h48; s_last = 1'b1; mode = ENC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
      chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_m_data",  {24'd0, m_data},  32'h31);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(8'h48, 1'b1, ENC, 8'h8A);
    drain();

    // key_we during RUN: flagged, key untouched
    send(8'h48, 1'b0, ENC, 8'h89);
    load_key(8'h00);
    chk("err_set", {31'd0, err}, 32'd1);
    chk("key_ok_run", {31'd0, key_ok}, 32'd1);
    send(8'h45, 1'b1, ENC, 8'h87);
    drain();

    // Rekey from ARMED
    load_key(8'h01);
    chk("rekey_key_ok_drop", {31'd0, key_ok}, 32'd0);
    chk("rekey_s_ready", {31'd0, s_ready}, 32'd0);
    load_key(8'h01);
    load_key(8'h01);
    chk("rekey_key_ok", {31'd0, key_ok}, 32'd1);
    send(8'h48, 1'b1, ENC, 8'h49);
    drain();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Reset mid-message with an output stalled
    m_ready = 1'b0;
    send(8'h10, 1'b0, ENC, 8'h11);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_key_ok", {31'd0, key_ok}, 32'd0);
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
    load_key(8'h41);
    load_key(8'h42);
    load_key(8'h43);
    send(8'h48, 1'b1, ENC, 8'h89);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
